mac_operand_seq: RTL and testbench

MAC_OPERAND_SEQ -- requirements
Module: mac_operand_seq

---
 rtl/mac_operand_seq_if.sv | 29 ++
 rtl/mac_operand_seq.sv | 141 ++++++++++++++
 tb/tb_mac_operand_seq.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_operand_seq_if.sv
// Signal bundle between the operand sequencer, its operand source, the MAC stage
// and the result consumer.
interface mac_operand_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        in_last;
    logic [7:0]  mac_a;
    logic [7:0]  mac_b;
    logic        mac_en;
    logic        mac_clr;
    logic [15:0] ac_val;
    logic        cout;
    logic        res_valid;
    logic        res_ready;
    logic [16:0] res_data;
    logic [7:0]  res_cnt;

    modport slave (
        input  in_valid, in_a, in_b, in_last, ac_val, cout, res_ready,
        output in_ready, mac_a, mac_b, mac_en, mac_clr, res_valid, res_data, res_cnt
    );

    modport master (
        output in_valid, in_a, in_b, in_last, ac_val, cout, res_ready,
        input  in_ready, mac_a, mac_b, mac_en, mac_clr, res_valid, res_data, res_cnt
    );
endinterface

// File: rtl/mac_operand_seq.sv
// Operand sequencer: buffers {last,a,b} pairs and streams one dot-product vector
// at a time into an external MAC, then captures {cout, ac_val} as the result.
//   state | meaning
//   CLEAR | mac_clr high for one cycle, element counter zeroed
//   RUN   | pop one pair per cycle while the FIFO holds data
//   DRAIN | two cycles for the MAC to absorb the final element
//   HOLD  | result presented until res_ready
module mac_operand_seq #(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    mac_operand_seq_if.slave bus
);
    localparam int          AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {CLEAR, RUN, DRAIN, HOLD} state_t;
    state_t state, state_nxt;

    logic [16:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          push, pop;
    logic [16:0]   head;

    logic [7:0]  mac_a_q, mac_a_d, mac_b_q, mac_b_d;
    logic        mac_en_q, mac_en_d, mac_clr_q, mac_clr_d;
    logic        res_valid_q, res_valid_d;
    logic [16:0] res_data_q, res_data_d;
    logic [7:0]  res_cnt_q, res_cnt_d;
    logic [7:0]  elem_cnt, elem_cnt_d;
    logic        drain_2nd, drain_2nd_d;

    // No pass-through: an empty FIFO cannot pop the pair being pushed this cycle.
    assign bus.in_ready = rst && (count != FULL);
    assign push         = bus.in_valid && bus.in_ready;
    assign pop          = (state == RUN) && (count != '0);
    assign head         = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {bus.in_last, bus.in_a, bus.in_b};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= CLEAR;
            mac_a_q     <= '0;
            mac_b_q     <= '0;
            mac_en_q    <= 1'b0;
            mac_clr_q   <= 1'b1;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_cnt_q   <= '0;
            elem_cnt    <= '0;
            drain_2nd   <= 1'b0;
        end else begin
            state       <= state_nxt;
            mac_a_q     <= mac_a_d;
            mac_b_q     <= mac_b_d;
            mac_en_q    <= mac_en_d;
            mac_clr_q   <= mac_clr_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_cnt_q   <= res_cnt_d;
            elem_cnt    <= elem_cnt_d;
            drain_2nd   <= drain_2nd_d;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            CLEAR:   state_nxt = RUN;
            RUN:     if (pop && head[16]) state_nxt = DRAIN;
            DRAIN:   if (drain_2nd) state_nxt = HOLD;
            HOLD:    if (res_valid_q && bus.res_ready) state_nxt = CLEAR;
            default: state_nxt = CLEAR;
        endcase
    end

    // Next values of the registered outputs; mac_clr tracks entry into CLEAR.
    always_comb begin
        mac_a_d     = mac_a_q;
        mac_b_d     = mac_b_q;
        mac_en_d    = 1'b0;
        mac_clr_d   = (state_nxt == CLEAR);
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_cnt_d   = res_cnt_q;
        elem_cnt_d  = elem_cnt;
        drain_2nd_d = 1'b0;
        case (state)
            CLEAR: elem_cnt_d = '0;
            RUN: begin
                if (pop) begin
                    mac_a_d  = head[15:8];
                    mac_b_d  = head[7:0];
                    mac_en_d = 1'b1;
                    if (elem_cnt != 8'hFF) elem_cnt_d = elem_cnt + 8'd1;
                end
            end
            DRAIN: begin
                drain_2nd_d = !drain_2nd;
                if (drain_2nd) begin
                    res_data_d  = {bus.cout, bus.ac_val};
                    res_cnt_d   = elem_cnt;
                    res_valid_d = 1'b1;
                end
            end
            HOLD: if (res_valid_q && bus.res_ready) res_valid_d = 1'b0;
            default: ;
        endcase
    end

    assign bus.mac_a     = mac_a_q;
    assign bus.mac_b     = mac_b_q;
    assign bus.mac_en    = mac_en_q;
    assign bus.mac_clr   = mac_clr_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_cnt   = res_cnt_q;
endmodule

// File: tb/tb_mac_operand_seq.sv
// Bench for mac_operand_seq: queue-based cycle model compared every cycle, an
// accumulating MAC stand-in, and directed vectors with literal expectations.
module tb_mac_operand_seq;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mac_operand_seq_if bus ();

    mac_operand_seq #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // MAC stage stand-in: 17-bit accumulator, carry bit exposed as cout.
    logic [16:0] acc = '0;
    always @(posedge clk) begin
        if (bus.mac_clr)     acc <= '0;
        else if (bus.mac_en) acc <= acc + ({9'd0, bus.mac_a} * {9'd0, bus.mac_b});
    end
    assign bus.ac_val = acc[15:0];
    assign bus.cout   = acc[16];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    bit started     = 0;

    // Reference model: pending pairs in a queue, dot product summed directly.
    logic [16:0] mq[$];
    int          ph;       // 0 clear, 1 run, 2/3 drain, 4 hold
    int          sum;
    int          nelem;
    logic        e_en, e_clr, e_rv;
    logic [7:0]  e_a, e_b, e_rc;
    logic [16:0] e_rd;

    always @(posedge clk) begin
        logic [16:0] ent;
        bit          take;
        cyc++;
        if (!rst) begin
            started = 1;
            mq.delete();
            ph = 0; sum = 0; nelem = 0;
            e_en = 0; e_clr = 1; e_rv = 0; e_a = 0; e_b = 0; e_rc = 0; e_rd = 0;
        end else begin
            take  = bus.in_valid && (mq.size() < DEPTH);
            e_en  = 0;
            e_clr = 0;
            case (ph)
                0: begin sum = 0; nelem = 0; ph = 1; end
                1: if (mq.size() > 0) begin
                    ent = mq.pop_front();
                    e_a = ent[15:8];
                    e_b = ent[7:0];
                    e_en = 1;
                    sum = sum + int'(ent[15:8]) * int'(ent[7:0]);
                    if (nelem < 255) nelem++;
                    if (ent[16]) ph = 2;
                end
                2: ph = 3;
                3: begin e_rv = 1; e_rd = 17'(sum); e_rc = 8'(nelem); ph = 4; end
                default: if (bus.res_ready) begin e_rv = 0; e_clr = 1; ph = 0; end
            endcase
            if (take) mq.push_back({bus.in_last, bus.in_a, bus.in_b});
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        chk(nm, act, exp);
    endtask

    int cur_run = 0;
    int max_run = 0;
    always @(negedge clk) begin
        if (started) begin
            vectors++;
            chk("in_ready",  32'(bus.in_ready),  32'(rst && (mq.size() < DEPTH)));
            chk("mac_en",    32'(bus.mac_en),    32'(e_en));
            chk("mac_clr",   32'(bus.mac_clr),   32'(e_clr));
            chk("mac_a",     32'(bus.mac_a),     32'(e_a));
            chk("mac_b",     32'(bus.mac_b),     32'(e_b));
            chk("res_valid", 32'(bus.res_valid), 32'(e_rv));
            chk("res_data",  32'(bus.res_data),  32'(e_rd));
            chk("res_cnt",   32'(bus.res_cnt),   32'(e_rc));
        end
        if (bus.mac_en === 1'b1) cur_run++;
        else cur_run = 0;
        if (cur_run > max_run) max_run = cur_run;
    end

    task automatic push_pair(input logic [7:0] a, input logic [7:0] b, input logic last);
        logic rdy;
        bit   done;
        done = 0;
        bus.in_valid = 1; bus.in_a = a; bus.in_b = b; bus.in_last = last;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk) rdy = bus.in_ready;
            @(posedge clk) #1;
            if (rdy) done = 1;
        end
        bus.in_valid = 0;
        if (!done) begin
            vectors++; miscompares++;
            $display("FAIL push_timeout: pair %0d,%0d never accepted", a, b);
        end
    endtask

    task automatic wait_result(output logic [16:0] rd, output logic [7:0] rc);
        bit found;
        found = 0; rd = 'x; rc = 'x;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (bus.res_valid === 1'b1) begin found = 1; rd = bus.res_data; rc = bus.res_cnt; end
        end
        @(posedge clk) #1;
        if (!found) begin
            vectors++; miscompares++;
            $display("FAIL result_timeout: res_valid never rose");
        end
    endtask

    logic [7:0]  pa [6] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6};
    logic        pl [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [16:0] rd;
    logic [7:0]  rc;
    int          t0, lat, n_acc, idx, n_clr;
    logic        rdy;

    initial begin
        bus.in_valid = 0; bus.in_a = 0; bus.in_b = 0; bus.in_last = 0; bus.res_ready = 1;
        rst = 0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        lit("rst_mac_clr",   32'(bus.mac_clr),   32'd1);
        lit("rst_mac_en",    32'(bus.mac_en),    32'd0);
        lit("rst_in_ready",  32'(bus.in_ready),  32'd0);
        lit("rst_res_valid", 32'(bus.res_valid), 32'd0);
        lit("rst_res_data",  32'(bus.res_data),  32'd0);
        @(posedge clk) #1;
        rst = 1;
        repeat (2) @(posedge clk);
        #1;

        // single pair, latency from pop to result
        push_pair(8'd3, 8'd5, 1'b1);
        t0 = -1;
        for (int i = 0; i < 20 && t0 < 0; i++) begin
            @(negedge clk);
            if (bus.mac_en === 1'b1) t0 = cyc;
        end
        lat = -1;
        for (int i = 0; i < 20 && lat < 0; i++) begin
            if (bus.res_valid === 1'b1) lat = cyc - t0;
            else @(negedge clk);
        end
        lit("single_latency", 32'(lat), 32'd2);
        lit("single_data",    32'(bus.res_data), 32'h0000F);
        lit("single_cnt",     32'(bus.res_cnt),  32'd1);
        @(posedge clk) #1;
        repeat (5) @(posedge clk);
        #1;

        // four pairs streamed back-to-back
        max_run = 0;
        push_pair(8'd1, 8'd2, 1'b0);
        push_pair(8'd3, 8'd4, 1'b0);
        push_pair(8'd5, 8'd6, 1'b0);
        push_pair(8'd7, 8'd8, 1'b1);
        wait_result(rd, rc);
        lit("stream_data",   32'(rd), 32'd100);
        lit("stream_cnt",    32'(rc), 32'd4);
        lit("stream_en_run", 32'(max_run), 32'd4);
        repeat (5) @(posedge clk);
        #1;

        // carry-out reaches res_data[16]
        push_pair(8'd255, 8'd255, 1'b0);
        push_pair(8'd255, 8'd255, 1'b1);
        wait_result(rd, rc);
        lit("carry_data", 32'(rd), 32'h1FC02);
        lit("carry_cnt",  32'(rc), 32'd2);
        repeat (5) @(posedge clk);
        #1;

        // consumer stalls: FIFO fills behind a held result
        bus.res_ready = 0;
        push_pair(8'd10, 8'd1, 1'b1);
        wait_result(rd, rc);
        lit("stall_first", 32'(rd), 32'd10);
        idx = 0; n_acc = 0;
        for (int c = 0; c < 20; c++) begin
            bus.in_valid = (idx < 6);
            if (idx < 6) begin bus.in_a = pa[idx]; bus.in_b = pa[idx]; bus.in_last = pl[idx]; end
            @(negedge clk) rdy = bus.in_ready;
            @(posedge clk) #1;
            if (rdy && idx < 6) begin idx++; n_acc++; end
        end
        bus.in_valid = 0;
        lit("stall_accepted", 32'(n_acc), 32'd4);
        @(negedge clk);
        lit("stall_in_ready", 32'(bus.in_ready), 32'd0);
        lit("stall_held",     32'(bus.res_data), 32'd10);
        @(posedge clk) #1;
        bus.res_ready = 1;
        n_clr = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.mac_clr === 1'b1) n_clr++;
        end
        @(posedge clk) #1;
        lit("stall_clr_pulse", 32'(n_clr), 32'd1);
        wait_result(rd, rc);
        lit("stall_vec_data", 32'(rd), 32'd30);
        lit("stall_vec_cnt",  32'(rc), 32'd4);
        push_pair(pa[4], pa[4], pl[4]);
        push_pair(pa[5], pa[5], pl[5]);
        wait_result(rd, rc);
        lit("stall_tail_data", 32'(rd), 32'd61);
        lit("stall_tail_cnt",  32'(rc), 32'd2);
        repeat (5) @(posedge clk);
        #1;

        // reset part-way through a vector
        push_pair(8'd1, 8'd1, 1'b0);
        push_pair(8'd2, 8'd2, 1'b0);
        @(posedge clk) #1;
        bus.in_valid = 1; bus.in_a = 8'd3; bus.in_b = 8'd3; bus.in_last = 1'b0;
        rst = 0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        lit("midrst_res_valid", 32'(bus.res_valid), 32'd0);
        lit("midrst_mac_clr",   32'(bus.mac_clr),   32'd1);
        lit("midrst_mac_en",    32'(bus.mac_en),    32'd0);
        lit("midrst_in_ready",  32'(bus.in_ready),  32'd0);
        @(posedge clk) #1;
        bus.in_valid = 0;
        rst = 1;
        @(negedge clk);
        lit("midrst_clear_first", 32'(bus.mac_clr), 32'd1);
        @(posedge clk) #1;
        push_pair(8'd2, 8'd3, 1'b1);
        wait_result(rd, rc);
        lit("midrst_data", 32'(rd), 32'd6);
        lit("midrst_cnt",  32'(rc), 32'd1);
        repeat (4) @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
